// File: rtl/pattern_pkg.sv
// Shared constants and the case-fold helper for the stream pattern matcher.
package pattern_pkg;

  localparam int CHAR_W = 8;

  localparam logic [CHAR_W-1:0] FOLD_LO  = 8'h41;
  localparam logic [CHAR_W-1:0] FOLD_HI  = 8'h5A;
  localparam logic [CHAR_W-1:0] FOLD_OFS = 8'h20;

  function automatic logic [CHAR_W-1:0] fold_char(input logic [CHAR_W-1:0] c,
                                                  input logic              nocase);
    logic [CHAR_W-1:0] r;
    if (nocase && (c >= FOLD_LO) && (c <= FOLD_HI)) begin
      r = c + FOLD_OFS;
    end else begin
      r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/pattern_cmp.sv
// Combinational compare of the newest-first byte window against the pattern.
module pattern_cmp
  import pattern_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN*CHAR_W-1:0] window,
  input  logic [MAX_LEN*CHAR_W-1:0] pattern,
  input  logic [LEN_W-1:0]          len,
  input  logic                      nocase,
  output logic                      hit
);

  logic [MAX_LEN-1:0] eq_s;
  int                 len_s;
  int                 sel_s;
  logic               len_ok_s;

  // Pattern byte i pairs with the window byte (len-1-i) positions back.
  always_comb begin
    eq_s     = '1;
    sel_s    = 0;
    len_s    = int'(len);
    len_ok_s = (len_s >= 1) && (len_s <= MAX_LEN);
    for (int i = 0; i < MAX_LEN; i++) begin
      sel_s   = (len_ok_s && (i < len_s)) ? (len_s - 1 - i) : 0;
      eq_s[i] = (i >= len_s) ||
                (fold_char(pattern[i*CHAR_W +: CHAR_W], nocase) ==
                 fold_char(window[sel_s*CHAR_W +: CHAR_W], nocase));
    end
    hit = len_ok_s && (&eq_s);
  end

endmodule

// File: rtl/stream_pattern_matcher.sv
// Byte-stream pattern detector: echoes the stream one cycle late with an aligned match pulse.
module stream_pattern_matcher
  import pattern_pkg::*;
#(
  parameter int  MAX_LEN = 8,
  parameter int  CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  input  logic                      cfg_load,
  input  logic [MAX_LEN*8-1:0]      cfg_pattern,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic                      cfg_nocase,
  input  logic                      cfg_overlap,
  output logic                      out_valid,
  output logic [7:0]                out_data,
  output logic                      match,
  output logic [CNT_W-1:0]          match_idx,
  output logic [CNT_W-1:0]          match_cnt
);

  localparam int HIST_W = (MAX_LEN - 1) * CHAR_W;

  logic [MAX_LEN*CHAR_W-1:0] cfg_pattern_r;
  logic [LEN_W-1:0]          cfg_len_r;
  logic                      cfg_nocase_r;
  logic                      cfg_overlap_r;
  // Only MAX_LEN-1 past bytes are stored; the live byte completes the window.
  logic [HIST_W-1:0]         hist_r;
  logic [LEN_W-1:0]          fill_r;
  logic [CNT_W-1:0]          idx_r;

  logic [MAX_LEN*CHAR_W-1:0] window_s;
  logic                      cmp_hit_s;
  logic                      fill_ok_s;
  logic                      hit_s;
  logic [LEN_W-1:0]          fill_inc_s;
  logic [CNT_W-1:0]          cnt_inc_s;

  assign window_s = {hist_r, in_data};

  pattern_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .window  (window_s),
    .pattern (cfg_pattern_r),
    .len     (cfg_len_r),
    .nocase  (cfg_nocase_r),
    .hit     (cmp_hit_s)
  );

  // Qualify the raw compare with fill depth and the load-wins rule.
  always_comb begin
    fill_ok_s  = ({1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, cfg_len_r};
    hit_s      = in_valid && !cfg_load && fill_ok_s && cmp_hit_s;
    fill_inc_s = (fill_r == LEN_W'(MAX_LEN)) ? fill_r : (fill_r + {{(LEN_W-1){1'b0}}, 1'b1});
    cnt_inc_s  = (&match_cnt) ? match_cnt : (match_cnt + {{(CNT_W-1){1'b0}}, 1'b1});
  end

  // Config, history, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pattern_r <= '0;
      cfg_len_r     <= '0;
      cfg_nocase_r  <= 1'b0;
      cfg_overlap_r <= 1'b1;
      hist_r        <= '0;
      fill_r        <= '0;
      idx_r         <= '0;
      out_valid     <= 1'b0;
      out_data      <= 8'h00;
      match         <= 1'b0;
      match_idx     <= '0;
      match_cnt     <= '0;
    end else begin
      out_valid <= in_valid;
      out_data  <= in_data;
      match     <= hit_s;
      if (cfg_load) begin
        cfg_pattern_r <= cfg_pattern;
        cfg_len_r     <= cfg_len;
        cfg_nocase_r  <= cfg_nocase;
        cfg_overlap_r <= cfg_overlap;
        hist_r        <= '0;
        fill_r        <= '0;
        idx_r         <= '0;
        match_cnt     <= '0;
      end else if (in_valid) begin
        hist_r <= window_s[HIST_W-1:0];
        idx_r  <= idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (hit_s) begin
          match_idx <= idx_r;
          match_cnt <= cnt_inc_s;
          // Non-overlap mode forgets consumed bytes so they cannot seed another match.
          fill_r    <= cfg_overlap_r ? fill_inc_s : '0;
        end else begin
          fill_r    <= fill_inc_s;
        end
      end else begin
        fill_r <= fill_r;
      end
    end
  end

endmodule

// File: tb/tb_stream_pattern_matcher.sv
// Directed self-checking bench for stream_pattern_matcher.
module tb_stream_pattern_matcher;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 cfg_load;
  logic [MAX_LEN*8-1:0] cfg_pattern;
  logic [LEN_W-1:0]     cfg_len;
  logic                 cfg_nocase;
  logic                 cfg_overlap;

  logic                 out_valid, match;
  logic [7:0]           out_data;
  logic [15:0]          match_idx, match_cnt;
  logic                 out_valid4, match4;
  logic [7:0]           out_data4;
  logic [3:0]           match_idx4, match_cnt4;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  stream_pattern_matcher #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_nocase(cfg_nocase), .cfg_overlap(cfg_overlap),
    .out_valid(out_valid), .out_data(out_data), .match(match),
    .match_idx(match_idx), .match_cnt(match_cnt)
  );

  stream_pattern_matcher #(.MAX_LEN(MAX_LEN), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_nocase(cfg_nocase), .cfg_overlap(cfg_overlap),
    .out_valid(out_valid4), .out_data(out_data4), .match(match4),
    .match_idx(match_idx4), .match_cnt(match_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAX_LEN*8-1:0] pack(input string s);
    logic [MAX_LEN*8-1:0] p;
    p = '0;
    for (int i = 0; i < s.len() && i < MAX_LEN; i++) p[i*8 +: 8] = s[i];
    return p;
  endfunction

  task automatic cfg(input string p, input int len, input logic nc, input logic ov);
    cfg_pattern = pack(p);
    cfg_len     = LEN_W'(len);
    cfg_nocase  = nc;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    @(posedge clk); #1;
    cfg_load    = 1'b0;
    chk("load_cnt_clear", 32'(match_cnt), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic exp_m, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_ovalid"}, 32'(out_valid), 32'd1);
    chk({tag, "_odata"}, 32'(out_data), 32'(d));
    chk({tag, "_match"}, 32'(match), 32'(exp_m));
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_idle_ovalid"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_match"}, 32'(match), 32'd0);
    end
  endtask

  task automatic stream(input string s, input int mask, input string tag);
    for (int i = 0; i < s.len(); i++) send(s[i], mask[i], tag);
  endtask

  initial begin
    string gap;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_nocase = 1'b0; cfg_overlap = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_odata", 32'(out_data), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_idx", 32'(match_idx), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    rst = 1'b0;

    // Case-insensitive "iloveyou": 'U' is stream index 8.
    cfg("iloveyou", 8, 1'b1, 1'b1);
    stream("xILoveYoUz", 32'h100, "nocase");
    chk("nocase_idx", 32'(match_idx), 32'd8);
    chk("nocase_cnt", 32'(match_cnt), 32'd1);

    cfg("iloveyou", 8, 1'b0, 1'b1);
    stream("xILoveYoUz", 32'h0, "case");
    chk("case_cnt", 32'(match_cnt), 32'd0);

    cfg("aaa", 3, 1'b0, 1'b1);
    stream("aaaaa", 32'h1C, "ovl1");
    chk("ovl1_idx", 32'(match_idx), 32'd4);
    chk("ovl1_cnt", 32'(match_cnt), 32'd3);

    cfg("aaa", 3, 1'b0, 1'b0);
    stream("aaaaa", 32'h04, "ovl0");
    chk("ovl0_idx", 32'(match_idx), 32'd2);
    chk("ovl0_cnt", 32'(match_cnt), 32'd1);

    // Gapped stream still matches on the final byte.
    cfg("iloveyou", 8, 1'b0, 1'b1);
    gap = "iloveyou";
    for (int i = 0; i < 8; i++) begin
      send(gap[i], (i == 7), "gap");
      idle(3, "gap");
    end
    chk("gap_idx", 32'(match_idx), 32'd7);
    chk("gap_cnt", 32'(match_cnt), 32'd1);

    // Load coinciding with the 4th byte: echoed, not stored, not counted.
    cfg("iloveyou", 8, 1'b0, 1'b1);
    stream("ilo", 32'h0, "ldpre");
    in_valid = 1'b1; in_data = "v"; cfg_load = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_load = 1'b0;
    chk("ld_ovalid", 32'(out_valid), 32'd1);
    chk("ld_odata", 32'(out_data), 32'h76);
    chk("ld_match", 32'(match), 32'd0);
    chk("ld_cnt", 32'(match_cnt), 32'd0);
    stream("eyou", 32'h0, "ldpost");
    stream("iloveyou", 32'h80, "ldfull");
    chk("ld_idx", 32'(match_idx), 32'd11);
    chk("ld_cnt2", 32'(match_cnt), 32'd1);

    cfg("iloveyou", 0, 1'b0, 1'b1);
    stream("iloveyou", 32'h0, "len0");
    chk("len0_cnt", 32'(match_cnt), 32'd0);
    cfg("iloveyou", 9, 1'b0, 1'b1);
    stream("iloveyouiloveyou", 32'h0, "len9");
    chk("len9_cnt", 32'(match_cnt), 32'd0);
    cfg("abcdefgh", 8, 1'b0, 1'b1);
    stream("abcdefgh", 32'h80, "len8");
    chk("len8_idx", 32'(match_idx), 32'd7);
    chk("len8_cnt", 32'(match_cnt), 32'd1);

    // Reset mid-match drops all state.
    cfg("aaa", 3, 1'b0, 1'b1);
    stream("aa", 32'h0, "rstmid");
    rst = 1'b1; in_valid = 1'b1; in_data = "a";
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rstmid_ovalid", 32'(out_valid), 32'd0);
    chk("rstmid_match", 32'(match), 32'd0);
    chk("rstmid_cnt", 32'(match_cnt), 32'd0);
    chk("rstmid_idx", 32'(match_idx), 32'd0);
    send("a", 1'b0, "rstpost");

    // 4-bit counters: count saturates at 15, index wraps to 0 on the 17th byte.
    cfg("q", 1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send("q", 1'b1, "sat");
      chk("sat_match4", 32'(match4), 32'd1);
      chk("sat_idx4", 32'(match_idx4), 32'(i % 16));
      chk("sat_cnt4", 32'(match_cnt4), 32'((i + 1 > 15) ? 15 : i + 1));
    end
    chk("sat_ovalid4", 32'(out_valid4), 32'd1);
    chk("sat_odata4", 32'(out_data4), 32'h71);
    chk("sat_cnt16", 32'(match_cnt), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/stream_pattern_matcher.md
# stream_pattern_matcher

Parametrised byte-stream pattern detector: next generation of the fixed "iloveyou" checker. Watches an 8-bit character stream and pulses a match flag when the last `cfg_len` accepted bytes equal a runtime-programmed pattern of up to `MAX_LEN` characters. Supports optional case-insensitive comparison, overlapping or non-overlapping match modes, and a saturating match counter. Sits between the character source and downstream flow logic; the input stream is echoed with one cycle of latency and the match flag is aligned to it.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bytes; must be ≥ 2.
- `CNT_W`, 16: width of `match_cnt` and `match_idx`.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of `cfg_len`; derived, do not override.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` is a stream byte this cycle.
- `in_data` in 8: stream byte.
- `cfg_load` in 1: single-cycle strobe; latches all `cfg_*` inputs.
- `cfg_pattern` in `MAX_LEN*8`: pattern bytes, first character in bits [7:0].
- `cfg_len` in `LEN_W`: number of pattern bytes in use.
- `cfg_nocase` in 1: case-insensitive compare when set.
- `cfg_overlap` in 1: overlapping matches allowed when set.
- `out_valid` out 1: registered copy of `in_valid`.
- `out_data` out 8: registered copy of `in_data`.
- `match` out 1: high with `out_valid` on the final byte of a match.
- `match_idx` out `CNT_W`: stream index (0-based, counts accepted bytes) of the final byte of the most recent match.
- `match_cnt` out `CNT_W`: total number of matches since reset or load; saturates.

## Operation
- Config registers hold pattern, len, nocase, overlap.
  - Reset values: pattern 0, len 0, nocase 0, overlap 1.
  - `cfg_load` updates them, clears the history, the fill count, `match_cnt` and the byte index.
- History: shift register of the last `MAX_LEN` accepted bytes plus a fill count `fill` that saturates at `MAX_LEN`.
  - Each `in_valid` byte shifts in and increments the byte index; the index wraps modulo 2^CNT_W.
- Case fold: with `cfg_nocase`=1, bytes 0x41–0x5A are mapped +0x20 on both the history and the pattern before compare. Other bytes are compared raw.
- Match condition, evaluated on the accepted byte:
  - 1 ≤ `cfg_len` ≤ `MAX_LEN`, and
  - `fill`+1 ≥ `cfg_len`, and
  - the newest `cfg_len` bytes, including the current one, equal `cfg_pattern` bytes 0..len-1 in order.
- On a match:
  - assert `match`;
  - load `match_idx` with the current byte index;
  - increment `match_cnt`, saturating at all-ones.
  - If `cfg_overlap`=0, reset `fill` to 0 so that no later match can reuse these bytes. With `cfg_overlap`=1, `fill` is unaffected.
- `cfg_len`=0 or `cfg_len`>`MAX_LEN`: never matches. The stream is still echoed.

## Timing
- All outputs are registered. Reset values: `out_valid`=0, `out_data`=0, `match`=0, `match_idx`=0, `match_cnt`=0.
- Latency: byte accepted in cycle N appears on `out_*` in N+1. `match` for that byte is also asserted in N+1. `match_idx` and `match_cnt` update in N+1.
- `match` is a one-cycle pulse and is only ever high when `out_valid` is high.
- `in_valid` may be high every cycle; there is no backpressure.
- `cfg_load` and `in_valid` in the same cycle:
  - load wins and the history is cleared;
  - the byte is echoed on `out_*` but is not shifted into history, not counted, and cannot match.
- `rst` mid-match: all state returns to reset values the next cycle and partial history is lost.
- Config inputs are ignored except in a `cfg_load` cycle.

## Structure
- Shared package `pattern_pkg`: `CHAR_W`=8, the case-fold constants (0x41, 0x5A, 0x20), and the function `fold_char(byte, nocase)`.
- One sub-module, `pattern_cmp`: a purely combinational compare of the history window against the pattern, using the length mask and case fold, producing a single `hit` bit.
- The top level holds the config registers, the history shift register, the fill/index counters and the output registers.

## Test plan
- Reset, then program "iloveyou" (len 8, nocase=1). Stream "xILoveYoUz" continuously:
  - `match`=1 only in the cycle after 'U' is accepted;
  - `match_idx`=8, `match_cnt`=1.
- Same stream with nocase=0: no match, and `match_cnt` stays 0.
- Pattern "aaa" (len 3), stream "aaaaa":
  - overlap=1 gives matches at indices 2, 3, 4 and `match_cnt`=3;
  - overlap=0 gives a match only at index 2 and `match_cnt`=1.
- Gapped stream: "iloveyou" with `in_valid` low for 3 cycles between each byte → a single match on 'u'. Assert `cfg_load` together with the 4th byte → the byte is echoed, there is no match, and the history is cleared.
- `cfg_len`=0 and `cfg_len`=`MAX_LEN`+1 each stream the pattern → no match ever. `cfg_len`=`MAX_LEN` with a full-length pattern → a match.
- `CNT_W`=4 and a repeated 1-byte pattern streamed 20 times → `match_cnt` saturates at 15. `match_idx` wraps: the 17th byte reports index 0.
